// File: rtl/alu_pkg.sv
// Shared op encodings, width defaults and the legal-op check for the logical/shift execute path.
// The encoding is {sel2,sel1,sel0}; codes 011 and 111 are unassigned.
package alu_pkg;

  localparam int DW_DEFAULT   = 32;
  localparam int SHW_DEFAULT  = 5;
  localparam int TAGW_DEFAULT = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

  // Both unassigned codes have the low two bits set.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/alu_logical.sv
// Combinational logical/shift unit: AND/OR/XOR/SLL/SRA/SRL on in1/in2 with the shift amount in in2[SHW-1:0].
// Zero latency and no flow control. Unassigned select codes produce 0.
module alu_logical
  import alu_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int SHW = SHW_DEFAULT
) (
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic          sel2,
  input  logic          sel1,
  input  logic          sel0,
  output logic [DW-1:0] out
);

  logic [2:0]     sel;
  logic [SHW-1:0] shamt;

  assign sel   = {sel2, sel1, sel0};
  assign shamt = in2[SHW-1:0];

  always_comb begin
    out = '0;
    case (sel)
      OP_AND:  out = in1 & in2;
      OP_OR:   out = in1 | in2;
      OP_XOR:  out = in1 ^ in2;
      OP_SLL:  out = in1 << shamt;
      OP_SRL:  out = in1 >> shamt;
      OP_SRA:  out = $signed(in1) >>> shamt;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register execute stage (OP -> alu_logical -> RES); 2-cycle latency, 1 op/cycle, holds up to 2 ops.
// out_ready low freezes RES and fills OP, then in_ready drops. Optional out_err via ALU_EXEC_ILLEGAL_OP_EN.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int SHW  = SHW_DEFAULT,
  parameter int TAGW = TAGW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_result,
  output logic [TAGW-1:0] out_tag,
`ifdef ALU_EXEC_ILLEGAL_OP_EN
  output logic            out_err,
`endif
  output logic            busy
);

  typedef struct packed {
    logic [2:0]      op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [TAGW-1:0] tag;
  } op_stage_t;

  op_stage_t       op_q;
  logic            op_vld;
  logic            res_vld;
  logic [DW-1:0]   res_result;
  logic [TAGW-1:0] res_tag;
  logic [DW-1:0]   alu_out;
  logic [DW-1:0]   res_nxt;
  logic            res_take;
  logic            op_adv;
  logic            in_xfer;

  // RES can take a new result when empty or draining this cycle.
  assign res_take = !res_vld || out_ready;
  assign op_adv   = op_vld && res_take;
  assign in_ready = !op_vld || res_take;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_q   <= '0;
    end else if (in_xfer) begin
      op_vld <= 1'b1;
      op_q   <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
    end else if (op_adv) begin
      op_vld <= 1'b0;
    end
  end

  alu_logical #(
    .DW  (DW),
    .SHW (SHW)
  ) alu_logical_0 (
    .in1  (op_q.a),
    .in2  (op_q.b),
    .sel2 (op_q.op[2]),
    .sel1 (op_q.op[1]),
    .sel0 (op_q.op[0]),
    .out  (alu_out)
  );

`ifdef ALU_EXEC_ILLEGAL_OP_EN
  logic op_legal;
  logic res_err;

  assign op_legal = is_legal_op(op_q.op);
  assign res_nxt  = op_legal ? alu_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err <= 1'b0;
    end else if (op_adv) begin
      res_err <= !op_legal;
    end
  end

  assign out_err = res_err;
`else
  assign res_nxt = alu_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld    <= 1'b0;
      res_result <= '0;
      res_tag    <= '0;
    end else if (op_adv) begin
      res_vld    <= 1'b1;
      res_result <= res_nxt;
      res_tag    <= op_q.tag;
    end else if (out_ready) begin
      res_vld    <= 1'b0;
    end
  end

  assign out_valid  = res_vld;
  assign out_result = res_result;
  assign out_tag    = res_tag;
  assign busy       = op_vld || res_vld;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector and scoreboard bench for alu_exec_stage: reset, back-to-back timing, stall, random flow, idle.
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int DW   = 32;
  localparam int TAGW = 5;
  localparam int NV   = 12;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_result;
  logic [TAGW-1:0] out_tag;
  logic            busy;
`ifdef ALU_EXEC_ILLEGAL_OP_EN
  logic            out_err;
`endif

  alu_exec_stage #(.DW(DW), .SHW(5), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
`ifdef ALU_EXEC_ILLEGAL_OP_EN
    .out_err    (out_err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  vec_t vecs [NV];
  exp_t expq [$];
  int   nvec = 0;
  int   nmis = 0;
  int   npop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b110:  return a << b[4:0];
      3'b101:  return a >> b[4:0];
      3'b100:  return $signed(a) >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op);
`ifdef ALU_EXEC_ILLEGAL_OP_EN
    return (op == 3'b011) || (op == 3'b111);
`else
    return (op == 3'b011) && (op == 3'b111);
`endif
  endfunction

  // One clock: drive at posedge+1, sample handshakes at posedge+2, score outputs against the queue.
  task automatic cycle_step(input logic v, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag, input logic ordy,
                            output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        npop++;
        chk("q_result", out_result, e.res);
        chk("q_tag", 32'(out_tag), 32'(e.tag));
`ifdef ALU_EXEC_ILLEGAL_OP_EN
        chk("q_err", 32'(out_err), 32'(e.err));
`endif
      end
    end
    if (acc) expq.push_back('{res: ref_alu(op, a, b), tag: tag, err: ref_err(op)});
  endtask

  logic [2:0] legal_ops [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    int   sent;
    int   cyc;
    logic have;
    vec_t pend;

    legal_ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b101, 3'b100};
    vecs[0]  = '{op: 3'b000, a: 32'h1,         b: 32'h1,         exp: 32'h1};
    vecs[1]  = '{op: 3'b001, a: 32'h1,         b: 32'h0,         exp: 32'h1};
    vecs[2]  = '{op: 3'b010, a: 32'h1,         b: 32'h1,         exp: 32'h0};
    vecs[3]  = '{op: 3'b110, a: 32'h30,        b: 32'h2,         exp: 32'hC0};
    vecs[4]  = '{op: 3'b101, a: 32'h0A,        b: 32'h1,         exp: 32'h5};
    vecs[5]  = '{op: 3'b100, a: 32'h8000_000F, b: 32'h4,         exp: 32'hF800_0000};
    vecs[6]  = '{op: 3'b000, a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, exp: 32'hF000_F000};
    vecs[7]  = '{op: 3'b001, a: 32'h1234_0000, b: 32'h0000_5678, exp: 32'h1234_5678};
    vecs[8]  = '{op: 3'b010, a: 32'hAAAA_AAAA, b: 32'hFFFF_0000, exp: 32'h5555_AAAA};
    vecs[9]  = '{op: 3'b110, a: 32'h1,         b: 32'hFFFF_FFFF, exp: 32'h8000_0000};
    vecs[10] = '{op: 3'b101, a: 32'h8000_0000, b: 32'h0000_003F, exp: 32'h1};
    vecs[11] = '{op: 3'b100, a: 32'h7FFF_FFFF, b: 32'h4,         exp: 32'h07FF_FFFF};

    // Reset held with live input traffic.
    rst_n = 1'b0; in_valid = 1'b1; in_op = 3'b010; in_a = $urandom; in_b = $urandom;
    in_tag = 5'd7; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_rel_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rel_busy", 32'(busy), 32'd0);

    // Back-to-back table: result exactly two edges after acceptance, then idle drain.
    for (int c = 0; c < NV + 4; c++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      if (c < NV) begin
        in_valid = 1'b1; in_op = vecs[c].op; in_a = vecs[c].a; in_b = vecs[c].b; in_tag = 5'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < NV) chk("b2b_in_ready", 32'(in_ready), 32'd1);
      if (c >= 2 && c - 2 < NV) begin
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", out_result, vecs[c-2].exp);
        chk("b2b_tag", 32'(out_tag), 32'(c - 2));
      end else begin
        chk("b2b_idle_valid", 32'(out_valid), 32'd0);
      end
      if (c == NV + 1) chk("idle_busy_hold", 32'(busy), 32'd1);
      if (c == NV + 2) chk("idle_busy_fall", 32'(busy), 32'd0);
    end

    // Reset asserted with two ops in flight.
    cycle_step(1'b1, vecs[3].op, vecs[3].a, vecs[3].b, 5'd1, 1'b0, acc);
    cycle_step(1'b1, vecs[4].op, vecs[4].a, vecs[4].b, 5'd2, 1'b0, acc);
    cycle_step(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, acc);
    @(posedge clk);
    #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end

    // Backpressure: 5 stalled cycles offering 3 ops.
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      cycle_step(1'b1, vecs[6+idx].op, vecs[6+idx].a, vecs[6+idx].b, 5'(20 + idx), 1'b0, acc);
      if (k >= 2) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_result", out_result, vecs[6].exp);
        chk("stall_hold_tag", 32'(out_tag), 32'd20);
      end
      if (acc) idx++;
    end
    chk("stall_accepts", 32'(idx), 32'd2);
    npop = 0;
    cyc  = 0;
    while ((idx < 3 || expq.size() != 0) && cyc < 20) begin
      cycle_step(idx < 3, vecs[6+(idx%3)].op, vecs[6+(idx%3)].a, vecs[6+(idx%3)].b,
                 5'(20 + idx), 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("stall_drain_count", 32'(npop), 32'd3);
    chk("stall_drain_left", 32'(expq.size()), 32'd0);

    // Random valid/ready traffic against the scoreboard.
    npop = 0; sent = 0; cyc = 0; have = 1'b0; pend = '0;
    while ((sent < 1000 || expq.size() != 0) && cyc < 20000) begin
      if (!have && sent < 1000) begin
        pend.op = legal_ops[$urandom_range(0, 5)];
        pend.a  = $urandom;
        pend.b  = $urandom;
        have    = 1'b1;
      end
      cycle_step(have && ($urandom_range(0, 3) != 0), pend.op, pend.a, pend.b, 5'(sent),
                 ($urandom_range(0, 2) != 0), acc);
      if (acc) begin
        have = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_popped", 32'(npop), 32'd1000);
    chk("rand_left", 32'(expq.size()), 32'd0);

`ifdef ALU_EXEC_ILLEGAL_OP_EN
    npop = 0;
    cycle_step(1'b1, 3'b011, 32'hFFFF_FFFF, 32'h1234_5678, 5'd9, 1'b1, acc);
    cycle_step(1'b1, 3'b000, 32'h0000_000F, 32'h0000_0003, 5'd10, 1'b1, acc);
    cycle_step(1'b1, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, acc);
    for (int k = 0; k < 4; k++) cycle_step(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1, acc);
    chk("illegal_popped", 32'(npop), 32'd3);
`endif

    // Final idle check.
    for (int k = 0; k < 3; k++) cycle_step(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1, acc);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
